// File: rtl/reg_cal_ready_pkg.sv
// Shared field layout and helpers for the multi-channel calibration-ready register.
package reg_cal_ready_pkg;

    localparam int READY_LSB = 0;
    localparam int DONE_LSB  = 8;
    localparam int TO_LSB    = 16;
    localparam int MAX_CH    = 8;

    typedef enum logic [1:0] {
        RW,
        W1C,
        RO
    } field_access_e;

    localparam field_access_e READY_ACCESS   = RW;
    localparam field_access_e DONE_ACCESS    = W1C;
    localparam field_access_e TIMEOUT_ACCESS = W1C;

    // Watchdog width; a disabled watchdog still reports a minimum width of 1 bit.
    function automatic int cnt_width(input int cyc);
        return (cyc < 1) ? 1 : $clog2(cyc + 1);
    endfunction

endpackage

// File: rtl/reg_register_cal_ready_mc_chan.sv
// One channel: READY (RW, auto-clear), DONE/TIMEOUT (W1C, hardware-set) and its watchdog.
module cal_ready_chan
    import reg_cal_ready_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wr_en,
    input  logic wr_ready,
    input  logic wr_done_clr,
    input  logic wr_to_clr,
    input  logic hw_ack,
    output logic ready,
    output logic done,
    output logic timeout
);

    logic ack_hit;
    logic expire;
    logic ready_next;

    assign ack_hit = ready & hw_ack;

    // A software write always decides READY, even when the handshake completes that cycle.
    always_comb begin
        ready_next = ready;
        if (wr_en) begin
            ready_next = wr_ready;
        end else if (ack_hit || expire) begin
            ready_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready   <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            ready <= ready_next;
            if (ack_hit) begin
                done <= 1'b1;
            end else if (wr_en && wr_done_clr) begin
                done <= 1'b0;
            end
            if (expire) begin
                timeout <= 1'b1;
            end else if (wr_en && wr_to_clr) begin
                timeout <= 1'b0;
            end
        end
    end

    generate
        if (TIMEOUT_CYC > 0) begin : g_wdog
            localparam int CW = cnt_width(TIMEOUT_CYC);
            logic [CW-1:0] cnt;

            assign expire = ready & ~hw_ack & (cnt == CW'(TIMEOUT_CYC - 1));

            // Counter follows READY: zero whenever READY is about to be low, or on re-arm.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                end else if (!ready_next || (wr_en && wr_ready)) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end else begin : g_no_wdog
            assign expire = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/reg_register_cal_ready_mc.sv
// Multi-channel calibration-ready control register: strobes, channel array, read mux and irq.
module reg_register_cal_ready_mc
    import reg_cal_ready_pkg::*;
#(
    parameter int REG_WIDTH   = 32,
    parameter int CH_NUM      = 8,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 reg_wr_sel,
    input  logic                 reg_wr_rd,
    input  logic [REG_WIDTH-1:0] reg_wr_data,
    output logic [REG_WIDTH-1:0] reg_rd_out,
    output logic                 f_ready_wr,
    output logic                 f_ready_rd,
    input  logic [CH_NUM-1:0]    hw_ack,
    output logic [CH_NUM-1:0]    ready_out,
    output logic [CH_NUM-1:0]    done_out,
    output logic                 irq_out
);

    logic              wr_en;
    logic              rd_en;
    logic [CH_NUM-1:0] timeout_vec;
    logic              unused_wr_data;

    assign wr_en = reg_wr_sel & reg_wr_rd;
    assign rd_en = reg_wr_sel & ~reg_wr_rd;

    // Reserved write bits are dropped.
    assign unused_wr_data = ^reg_wr_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_ready_wr <= 1'b0;
            f_ready_rd <= 1'b0;
        end else begin
            f_ready_wr <= wr_en;
            f_ready_rd <= rd_en;
        end
    end

    generate
        for (genvar c = 0; c < CH_NUM; c++) begin : g_chan
            cal_ready_chan #(
                .TIMEOUT_CYC (TIMEOUT_CYC)
            ) u_chan (
                .clk         (clk),
                .rst_n       (rst_n),
                .wr_en       (wr_en),
                .wr_ready    (reg_wr_data[READY_LSB + c]),
                .wr_done_clr (reg_wr_data[DONE_LSB + c]),
                .wr_to_clr   (reg_wr_data[TO_LSB + c]),
                .hw_ack      (hw_ack[c]),
                .ready       (ready_out[c]),
                .done        (done_out[c]),
                .timeout     (timeout_vec[c])
            );
        end
    endgenerate

    always_comb begin
        reg_rd_out = '0;
        reg_rd_out[READY_LSB +: CH_NUM] = ready_out;
        reg_rd_out[DONE_LSB  +: CH_NUM] = done_out;
        reg_rd_out[TO_LSB    +: CH_NUM] = timeout_vec;
    end

    assign irq_out = |{done_out, timeout_vec};

endmodule

// File: tb/tb_reg_register_cal_ready_mc.sv
// Directed bench for reg_register_cal_ready_mc: vector table plus multi-cycle corner sequences.
module tb_reg_register_cal_ready_mc;

    localparam int CH = 8;
    localparam int TO = 16;

    logic        clk;
    logic        rst_n;
    logic        reg_wr_sel;
    logic        reg_wr_rd;
    logic [31:0] reg_wr_data;
    logic [31:0] reg_rd_out;
    logic        f_ready_wr;
    logic        f_ready_rd;
    logic [7:0]  hw_ack;
    logic [7:0]  ready_out;
    logic [7:0]  done_out;
    logic        irq_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        sel;
        logic        wr_rd;
        logic [31:0] data;
        logic [7:0]  ack;
        logic [7:0]  exp_ready;
        logic [7:0]  exp_done;
        logic [31:0] exp_rd;
        logic        exp_irq;
        logic        exp_fwr;
        logic        exp_frd;
    } vec_t;

    vec_t vecs[11];

    reg_register_cal_ready_mc #(
        .REG_WIDTH   (32),
        .CH_NUM      (CH),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .reg_wr_sel  (reg_wr_sel),
        .reg_wr_rd   (reg_wr_rd),
        .reg_wr_data (reg_wr_data),
        .reg_rd_out  (reg_rd_out),
        .f_ready_wr  (f_ready_wr),
        .f_ready_rd  (f_ready_rd),
        .hw_ack      (hw_ack),
        .ready_out   (ready_out),
        .done_out    (done_out),
        .irq_out     (irq_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic sel, input logic wr_rd,
                                 input logic [31:0] data, input logic [7:0] ack);
        reg_wr_sel  = sel;
        reg_wr_rd   = wr_rd;
        reg_wr_data = data;
        hw_ack      = ack;
        @(posedge clk);
        #1;
        reg_wr_sel  = 1'b0;
        reg_wr_rd   = 1'b0;
        reg_wr_data = 32'h0;
        hw_ack      = 8'h00;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkState(input string tag, input logic [7:0] rdy, input logic [7:0] dn,
                              input logic [31:0] rd, input logic irq);
        checkOutput({tag, " ready_out"}, 32'(ready_out), 32'(rdy));
        checkOutput({tag, " done_out"}, 32'(done_out), 32'(dn));
        checkOutput({tag, " reg_rd_out"}, reg_rd_out, rd);
        checkOutput({tag, " irq_out"}, 32'(irq_out), 32'(irq));
    endtask

    initial begin
        // sel, wr_rd, data, ack, ready, done, rd, irq, fwr, frd
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0000, 8'h00, 8'h00, 8'h00, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 32'h0000_0000, 8'h00, 8'h00, 8'h00, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 32'h0000_0005, 8'h00, 8'h05, 8'h00, 32'h0000_0005, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0000_0000, 8'h00, 8'h05, 8'h00, 32'h0000_0005, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0000_0000, 8'h00, 8'h05, 8'h00, 32'h0000_0005, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 32'h0000_0000, 8'h01, 8'h04, 8'h01, 32'h0000_0104, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0000, 8'h00, 8'h04, 8'h01, 32'h0000_0104, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 32'h0000_0104, 8'h00, 8'h04, 8'h00, 32'h0000_0004, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 32'h0000_0000, 8'h00, 8'h00, 8'h00, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 32'h0000_0000, 8'h02, 8'h00, 8'h00, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 32'hFF00_0000, 8'h00, 8'h00, 8'h00, 32'h0000_0000, 1'b0, 1'b1, 1'b0};

        rst_n       = 1'b0;
        reg_wr_sel  = 1'b0;
        reg_wr_rd   = 1'b0;
        reg_wr_data = 32'h0;
        hw_ack      = 8'h00;
        #3;
        checkState("reset", 8'h00, 8'h00, 32'h0, 1'b0);
        checkOutput("reset f_ready_wr", 32'(f_ready_wr), 32'h0);
        checkOutput("reset f_ready_rd", 32'(f_ready_rd), 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].sel, vecs[i].wr_rd, vecs[i].data, vecs[i].ack);
            checkState($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_done,
                       vecs[i].exp_rd, vecs[i].exp_irq);
            checkOutput($sformatf("vec%0d f_ready_wr", i), 32'(f_ready_wr), 32'(vecs[i].exp_fwr));
            checkOutput($sformatf("vec%0d f_ready_rd", i), 32'(f_ready_rd), 32'(vecs[i].exp_frd));
        end

        // Watchdog: READY[1] must survive 15 edges after the write and drop on the 16th.
        applyStimulus(1'b1, 1'b1, 32'h0000_0002, 8'h00);
        checkState("to armed", 8'h02, 8'h00, 32'h0000_0002, 1'b0);
        for (int i = 1; i <= TO - 1; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 8'h00);
            if (i == TO - 1) checkState("to edge15", 8'h02, 8'h00, 32'h0000_0002, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 8'h00);
        checkState("to expired", 8'h00, 8'h00, 32'h0002_0000, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h0002_0000, 8'h00);
        checkState("to cleared", 8'h00, 8'h00, 32'h0, 1'b0);

        // Re-arming every 10 cycles keeps the watchdog from expiring.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b1, 32'h0000_0002, 8'h00);
            for (int j = 0; j < 9; j++) applyStimulus(1'b0, 1'b0, 32'h0, 8'h00);
            checkState($sformatf("rearm%0d", k), 8'h02, 8'h00, 32'h0000_0002, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 32'h0000_0000, 8'h00);
        checkState("rearm off", 8'h00, 8'h00, 32'h0, 1'b0);

        // Ack coinciding with a write: write keeps READY, hardware set beats W1C.
        applyStimulus(1'b1, 1'b1, 32'h0000_0008, 8'h00);
        applyStimulus(1'b0, 1'b0, 32'h0, 8'h00);
        checkState("coll pre", 8'h08, 8'h00, 32'h0000_0008, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h0000_0808, 8'h08);
        checkState("coll", 8'h08, 8'h08, 32'h0000_0808, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h0000_0800, 8'h00);
        checkState("coll clr", 8'h00, 8'h00, 32'h0, 1'b0);

        // Asynchronous reset with all channels armed and a write strobe pending.
        applyStimulus(1'b1, 1'b1, 32'h0000_00FF, 8'h00);
        for (int j = 0; j < 5; j++) applyStimulus(1'b0, 1'b0, 32'h0, 8'h00);
        checkState("rst pre", 8'hFF, 8'h00, 32'h0000_00FF, 1'b0);
        reg_wr_sel  = 1'b1;
        reg_wr_rd   = 1'b1;
        reg_wr_data = 32'h0000_00FF;
        @(posedge clk);
        #2;
        checkOutput("rst pre f_ready_wr", 32'(f_ready_wr), 32'h1);
        rst_n       = 1'b0;
        reg_wr_sel  = 1'b0;
        reg_wr_rd   = 1'b0;
        reg_wr_data = 32'h0;
        #1;
        checkState("rst async", 8'h00, 8'h00, 32'h0, 1'b0);
        checkOutput("rst async f_ready_wr", 32'(f_ready_wr), 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < TO + 4; j++) applyStimulus(1'b0, 1'b0, 32'h0, 8'h00);
        checkState("rst post", 8'h00, 8'h00, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
